// File: rtl/serial_word_add_sub_if.sv
// Word-level handshake bundle for the serial add/sub unit:
// operand request, result response and serial debug tap.
interface serial_word_add_sub_if #(
    parameter int W = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_res;
    logic         out_cout;
    logic         out_ovf;
    logic         ser_bit;
    logic         ser_valid;

    modport slave (
        input  in_valid, in_a, in_b, in_sub, out_ready,
        output in_ready, out_valid, out_res,
        output out_cout, out_ovf, ser_bit, ser_valid
    );

    modport master (
        output in_valid, in_a, in_b, in_sub, out_ready,
        input  in_ready, out_valid, out_res,
        input  out_cout, out_ovf, ser_bit, ser_valid
    );
endinterface

// File: rtl/serial_word_add_sub.sv
// Word-parallel front/back end around a bit-serial
// adder: one result bit per clock, single carry flop.
module serial_word_add_sub #(
    parameter int W = 16
) (
    input logic                 clk,
    input logic                 rst,
    serial_word_add_sub_if.slave bus
);
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [W-1:0]  sa;
    logic [W-1:0]  sb;
    logic [W-1:0]  res;
    logic [CW-1:0] cnt;
    logic          carry;
    logic          c_msb_in;
    logic          sum_bit;
    logic          cy_nxt;
    logic          last;
    logic          accept;

    assign sum_bit = sa[0] ^ sb[0] ^ carry;
    assign cy_nxt  = (sa[0] & sb[0]) |
                     (sa[0] & carry) |
                     (sb[0] & carry);
    assign last    = (cnt == CW'(W - 1));
    assign accept  = (state_q == IDLE) && bus.in_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.in_valid)  state_d = RUN;
            RUN:     if (last)          state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    // Subtract is A + ~B + 1: invert B and seed the carry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sa       <= '0;
            sb       <= '0;
            res      <= '0;
            cnt      <= '0;
            carry    <= 1'b0;
            c_msb_in <= 1'b0;
        end else if (accept) begin
            sa    <= bus.in_a;
            sb    <= bus.in_sub ? ~bus.in_b : bus.in_b;
            carry <= bus.in_sub;
            cnt   <= '0;
        end else if (state_q == RUN) begin
            sa    <= {1'b0, sa[W-1:1]};
            sb    <= {1'b0, sb[W-1:1]};
            res   <= {sum_bit, res[W-1:1]};
            carry <= cy_nxt;
            cnt   <= cnt + 1'b1;
            if (cnt == CW'(W - 2))
                c_msb_in <= cy_nxt;
        end
    end

    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.ser_valid = (state_q == RUN);
        bus.ser_bit   = (state_q == RUN) & sum_bit;
        bus.out_valid = (state_q == DONE);
        bus.out_res   = '0;
        bus.out_cout  = 1'b0;
        bus.out_ovf   = 1'b0;
        if (state_q == DONE) begin
            bus.out_res  = res;
            bus.out_cout = carry;
            bus.out_ovf  = c_msb_in ^ carry;
        end
    end
endmodule

// File: doc/serial_word_add_sub.md
Name: serial_word_add_sub

Overview:
- Word-level wrapper around a bit-serial adder datapath.
- Accepts two parallel W-bit operands and an add/subtract select over a valid/ready handshake.
- Serializes the operands LSB-first and computes one result bit per clock with a single carry flop.
- Deserializes the result and presents it with carry and overflow flags over a second valid/ready handshake.
- Sits between a parallel producer and consumer; it is the parallel-to-serial front end and serial-to-parallel back end for the serial adder core.

Parameters:
- W, 16, operand and result width in bits (W >= 2).

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- in_valid  input  1  operand word valid.
- in_ready  output  1  block can accept operands.
- in_a  input  W  operand A.
- in_b  input  W  operand B.
- in_sub  input  1  0 = A+B, 1 = A-B.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_res  output  W  result, modulo 2^W.
- out_cout  output  1  final carry out (subtract: 1 = no borrow, i.e. A >= B unsigned).
- out_ovf  output  1  two's-complement signed overflow.
- ser_bit  output  1  result bit computed this cycle (debug/observability).
- ser_valid  output  1  ser_bit is meaningful.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; shift registers, carry, bit counter and result register cleared.
  - Outputs during and after reset: in_ready=1, out_valid=0, out_res=0, out_cout=0, out_ovf=0, ser_bit=0, ser_valid=0.
  - Reset mid-operation aborts the word; nothing is emitted.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On clock edge with in_valid=1: capture sa<=in_a, sb<=(in_sub ? ~in_b : in_b), carry<=in_sub, cnt<=0; go RUN.
  - in_valid=0: stay IDLE.
- RUN:
  - in_ready=0, ser_valid=1, ser_bit = sa[0]^sb[0]^carry.
  - Each edge:
    - carry <= majority(sa[0],sb[0],carry).
    - sa, sb shift right by 1.
    - res <= {ser_bit, res[W-1:1]}.
    - cnt++.
  - On the edge where cnt==W-2 is about to become W-1: latch c_msb_in = carry. This is the carry into the MSB.
  - On the edge with cnt==W-1: go DONE.
  - RUN lasts exactly W cycles.
- DONE:
  - out_valid=1, in_ready=0, ser_valid=0.
  - out_res=res, out_cout=carry, out_ovf=c_msb_in^carry.
  - All outputs are held stable while out_ready=0.
  - On edge with out_ready=1: go IDLE; out_valid drops next cycle.
- Outputs outside DONE: out_res, out_cout and out_ovf read 0 whenever out_valid=0.
- Latency: accept edge T, out_valid=1 in the cycle after edge T+W.
  - Minimum initiation interval is W+2 cycles (IDLE, W×RUN, DONE).
- in_valid while not IDLE: ignored, operands not sampled. The producer must hold until in_ready.
- in_a/in_b changes during RUN have no effect (operands are captured).
- Width rule: result is truncated to W bits. Carry and overflow are reported separately, never folded into out_res.

Test Plan:
- Add, W=16: a=0x4DB4, b=0x1D62, sub=0 -> out_res=0x6B16, cout=0, ovf=0; ser_bit LSB-first = bits of 0x6B16 over 16 RUN cycles; out_valid exactly 16 cycles after accept edge.
- Subtract: a=0x4DB4, b=0x1D62, sub=1 -> out_res=0x3052, cout=1, ovf=0.
- Wrap/overflow:
  - 0xFFFF+0x0001 -> 0x0000, cout=1, ovf=0.
  - 0x7FFF+0x0001 -> 0x8000, cout=0, ovf=1.
  - 0x0000-0x0001 -> 0xFFFF, cout=0, ovf=0.
  - 0x8000-0x0001 -> 0x7FFF, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new operands -> out_valid, out_res, out_cout, out_ovf stable and in_ready=0 throughout. Then out_ready=1 -> IDLE next cycle; new operands accepted and correct.
- Reset mid-RUN: assert rst=0 after bit 7 of a word -> immediately in_ready=1, out_valid=0, ser_valid=0, all outputs 0. After release, 0x1234+0x1111 -> 0x2345, cout=0, ovf=0.
- Back-to-back: in_valid held high with out_ready=1 across 3 words -> each accepted exactly once, results in order, accept edges spaced W+2 cycles apart.
